// File: rtl/emu_time_manager.sv
// emu_time_manager: global emulation timestep arbiter.
// Picks the smallest active timestep request, clamps it so emulated time lands
// exactly on the stop time, and broadcasts it combinationally as emu_dt.
// Also holds the emulated-time accumulator and the run/step/stop FSM.
// Optional statistics outputs are enabled by defining EMU_TIME_MGR_STATS_EN.
module emu_time_manager #(
    parameter int N_REQ      = 4,
    parameter int DT_WIDTH   = 27,
    parameter int TIME_WIDTH = 40,
    parameter int DT_MAX     = 2**(DT_WIDTH-1)-1,
    parameter int STEP_WIDTH = 16
) (
    input  logic                          emu_clk,
    input  logic                          emu_rst,
    input  logic [N_REQ*DT_WIDTH-1:0]     dt_req,
    input  logic [N_REQ-1:0]              req_mask,
    input  logic                          ctrl_run,
    input  logic                          ctrl_step,
    input  logic [STEP_WIDTH-1:0]         step_count,
    input  logic                          stop_en,
    input  logic [TIME_WIDTH-1:0]         stop_time,
    output logic signed [DT_WIDTH-1:0]    emu_dt,
    output logic [TIME_WIDTH-1:0]         emu_time,
    output logic [1:0]                    state_o,
    output logic                          busy
`ifdef EMU_TIME_MGR_STATS_EN
    ,
    output logic [31:0]                   cyc_cnt,
    output logic [$clog2(N_REQ)-1:0]      limit_idx,
    output logic [31:0]                   zero_dt_cnt
`endif
);

    localparam logic signed [DT_WIDTH-1:0] DT_MAX_V = DT_WIDTH'(DT_MAX);
    localparam int PAD_W = TIME_WIDTH + 1 - DT_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                        state;
    logic [STEP_WIDTH-1:0]         step_cnt;
    logic signed [DT_WIDTH-1:0]    dt_min;
    logic signed [DT_WIDTH-1:0]    dt_eff;
    logic signed [DT_WIDTH-1:0]    slot;
    logic                          found;
    logic                          run_phase;
    logic [TIME_WIDTH:0]           time_x;
    logic [TIME_WIDTH:0]           stop_x;
    logic [TIME_WIDTH:0]           reach_x;
    logic [TIME_WIDTH:0]           sum_x;
    logic [TIME_WIDTH-1:0]         time_next;
    logic                          stop_hit;
    logic                          entry_stop;

    // Signed minimum over participating, non-negative requests; DT_MAX if none qualify
    always_comb begin
        dt_min = DT_MAX_V;
        found  = 1'b0;
        slot   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            slot = $signed(dt_req[i*DT_WIDTH +: DT_WIDTH]);
            if (req_mask[i] && slot >= 0 && (!found || slot < dt_min)) begin
                dt_min = slot;
                found  = 1'b1;
            end
        end
        if (dt_min > DT_MAX_V) begin
            dt_min = DT_MAX_V;
        end
    end

    // One extra bit on every time comparison keeps the sums from wrapping
    assign time_x  = {1'b0, emu_time};
    assign stop_x  = {1'b0, stop_time};
    assign reach_x = time_x + {{PAD_W{1'b0}}, dt_min};

    // Shorten the step so time lands exactly on stop_time; never go backwards
    always_comb begin
        dt_eff = dt_min;
        if (stop_en && reach_x > stop_x) begin
            dt_eff = (stop_time > emu_time) ? DT_WIDTH'(stop_time - emu_time) : '0;
        end
    end

    assign run_phase = (state == S_RUN) || (state == S_STEP);
    assign emu_dt    = (!emu_rst && run_phase) ? dt_eff : '0;
    assign state_o   = state;

    assign sum_x      = time_x + {{PAD_W{1'b0}}, emu_dt};
    assign time_next  = sum_x[TIME_WIDTH] ? '1 : sum_x[TIME_WIDTH-1:0];
    assign stop_hit   = stop_en && (sum_x >= stop_x);
    assign entry_stop = stop_en && (stop_time <= emu_time);

    // Control FSM and time accumulator; busy follows the next state
    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            state    <= S_IDLE;
            emu_time <= '0;
            step_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            emu_time <= time_next;
            case (state)
                S_IDLE: begin
                    if (ctrl_step && step_count != '0) begin
                        step_cnt <= step_count;
                        state    <= entry_stop ? S_DONE : S_STEP;
                        busy     <= !entry_stop;
                    end else if (ctrl_run) begin
                        state <= entry_stop ? S_DONE : S_RUN;
                        busy  <= !entry_stop;
                    end
                end
                S_RUN: begin
                    if (stop_hit) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                    end else if (!ctrl_run) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_STEP: begin
                    step_cnt <= step_cnt - STEP_WIDTH'(1);
                    if (stop_hit) begin
                        state    <= S_DONE;
                        step_cnt <= '0;
                        busy     <= 1'b0;
                    end else if (step_cnt == STEP_WIDTH'(1)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (!stop_en || stop_time > emu_time) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef EMU_TIME_MGR_STATS_EN
    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] win_idx;

    // Lowest-index participating slot whose request equals the chosen minimum
    always_comb begin
        win_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_mask[i] && $signed(dt_req[i*DT_WIDTH +: DT_WIDTH]) >= 0 &&
                $signed(dt_req[i*DT_WIDTH +: DT_WIDTH]) == dt_min) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    // Saturating activity counters and registered limiting-slot index
    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            cyc_cnt     <= '0;
            zero_dt_cnt <= '0;
            limit_idx   <= '0;
        end else begin
            limit_idx <= win_idx;
            if (run_phase && cyc_cnt != '1) begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end
            if (run_phase && emu_dt == '0 && zero_dt_cnt != '1) begin
                zero_dt_cnt <= zero_dt_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/emu_time_manager.md
Name: emu_time_manager

Overview:
- Global emulation timestep arbiter that sits directly upstream of every MSDSL analog core, including the oscillator model.
- Collects each model's requested timestep (dt_req), picks the smallest, and drives it back to all models as emu_dt.
- Holds the emulated-time accumulator and the run/step/stop control FSM that the host debug interface uses to start, single-step and halt emulation.

Parameters:
N_REQ, 4, number of dt_req inputs
DT_WIDTH, 27, width of signed timestep words (matches `DT_WIDTH)
TIME_WIDTH, 40, width of unsigned emulated-time accumulator
DT_MAX, 2**(DT_WIDTH-1)-1, timestep issued when no request is active
STEP_WIDTH, 16, width of step counter

Ports:
emu_clk  in  1  emulator clock
emu_rst  in  1  reset; synchronous, active-high
dt_req  in  N_REQ*DT_WIDTH  packed signed timestep requests; slot i = bits [i*DT_WIDTH +: DT_WIDTH]
req_mask  in  N_REQ  1 = slot participates
ctrl_run  in  1  level; free-run while high
ctrl_step  in  1  one-cycle pulse; start a step burst
step_count  in  STEP_WIDTH  number of steps in a burst; sampled on ctrl_step
stop_en  in  1  enable stop-time comparison
stop_time  in  TIME_WIDTH  halt when emu_time reaches this value
emu_dt  out  DT_WIDTH  signed timestep broadcast to all models
emu_time  out  TIME_WIDTH  accumulated emulated time (registered)
state_o  out  2  FSM state: IDLE=0, RUN=1, STEP=2, DONE=3
busy  out  1  high in RUN or STEP

Behaviour:
- emu_dt is combinational, same cycle as dt_req. Models depend on this; no register is allowed in this path.
- Arbitration:
  - dt_min = signed minimum over slots with req_mask[i]=1 and dt_req[i] >= 0.
  - Negative or masked slots are ignored.
  - If no slot qualifies, dt_min = DT_MAX.
  - dt_min is clamped to DT_MAX.
- Stop clamp: if stop_en=1 and emu_time + dt_min > stop_time, then dt_eff = stop_time - emu_time. Otherwise dt_eff = dt_min. Compare at TIME_WIDTH+1 bits so there is no wrap.
- Output gating: emu_dt = dt_eff in RUN or STEP; emu_dt = 0 in IDLE or DONE.
- Time accumulator: emu_time <= emu_time + emu_dt every cycle, zero-extended. Adding 0 holds the value. Saturates at 2**TIME_WIDTH-1; it never wraps.
- FSM, with priority emu_rst > stop > step > run:
  - IDLE:
    - ctrl_step=1 and step_count != 0 → STEP; load step_cnt = step_count.
    - else ctrl_run=1 → RUN.
    - ctrl_step with step_count=0 is ignored.
  - RUN:
    - stop_en=1 and emu_time+emu_dt >= stop_time this cycle → DONE.
    - else ctrl_run=0 → IDLE.
    - ctrl_step is ignored.
  - STEP:
    - Each cycle decrements step_cnt.
    - Stop condition as in RUN → DONE; this has priority over step exhaustion.
    - else step_cnt==1 → IDLE.
    - ctrl_run and ctrl_step are ignored until the burst ends.
  - DONE:
    - Holds with emu_dt=0.
    - Exits to IDLE only when stop_en=0 or stop_time > emu_time is sampled.
- Stop at entry: stop_en=1 with stop_time <= emu_time while in IDLE means RUN and STEP are entered but go to DONE the same cycle, with emu_dt=0.
- Reset (synchronous, emu_rst=1 at a rising edge):
  - Effects: state=IDLE, emu_time=0, step_cnt=0, busy=0.
  - emu_dt is 0 during reset regardless of state.
  - Reset mid-burst discards the remaining steps.
- busy is registered from next-state, so it is valid the cycle after a transition.

Optional Feature:
- Macro: EMU_TIME_MGR_STATS_EN.
- When defined:
  - Adds outputs cyc_cnt[31:0] (cycles spent in RUN or STEP) and limit_idx[$clog2(N_REQ)-1:0] (registered index of the slot that set dt_min last cycle; lowest index wins ties).
  - Adds zero_dt_cnt[31:0], which counts busy cycles with emu_dt=0.
  - All counters reset to 0 and saturate.
- When undefined: these ports and registers do not exist; everything else is identical.

Test Plan:
1. Min arbitration: N_REQ=4, mask=1111, dt_req={100,40,-5,70}, ctrl_run=1 → emu_dt=40 the same cycle; emu_time advances by 40 per cycle (0,40,80,...).
2. No request: mask=0000 in RUN → emu_dt=DT_MAX; IDLE with any dt_req → emu_dt=0 and emu_time held.
3. Step burst: ctrl_step pulse with step_count=3, dt_min=10 → exactly 3 cycles in STEP with emu_dt=10, then IDLE; emu_time=30; ctrl_run toggling during the burst has no effect.
4. Stop clamp: stop_en=1, stop_time=95, dt_min=40, RUN → emu_dt sequence 40,40,15 then DONE; emu_time=95; emu_dt=0 after; raising stop_time to 200 returns to IDLE.
5. Reset mid-STEP: step_count=10, assert emu_rst at step 4 → next cycle state=IDLE, emu_time=0, busy=0, emu_dt=0.
6. With EMU_TIME_MGR_STATS_EN: dt_req={50,20,20,90} in RUN for 5 cycles → limit_idx=1, cyc_cnt=5, zero_dt_cnt=0.
